dds_sweep_ctrl: RTL
===================

# dds_sweep_ctrl

Sequencer that drives the frequency control word and phase offset of the DDS wave core. It accepts one sweep command over a valid/ready handshake and steps K linearly through a programmed list of tones, holding each tone for a programmed dwell. It supports single-shot, repeating and triangle (up-down) sweeps. It sits directly upstream of the DDS core: its K and P outputs connect to the core's K and P inputs.

## Interface
- KW, 32: width of the frequency control word K.
- PW, 11: width of the phase offset P; it matches the ROM address width.
- CW, 16: width of the step-count field.
- DW, 16: width of the dwell-count field.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- cfg_valid  in  1  a command is present on the cfg_* inputs.
- cfg_ready  out  1  the block can accept a command. Equals (state==IDLE) && !abort.
- cfg_k_start  in  KW  K of the first tone.
- cfg_k_step  in  KW  K increment per tone, two's complement. A negative step gives a down-sweep.
- cfg_steps  in  CW  increments per leg, S. Tones per leg = S+1.
- cfg_dwell  in  DW  cycles each tone is held, D. A value of 0 is treated as 1.
- cfg_phase  in  PW  phase offset P, held constant for the whole command.
- cfg_mode  in  2  0 = single, 1 = repeat, 2 = triangle, 3 = reserved (handled as single).
- abort  in  1  terminates the sweep in progress.
- K  out  KW  frequency word to the DDS core (registered).
- P  out  PW  phase offset to the DDS core (registered).
- busy  out  1  high while in the DWELL state.
- tone_strobe  out  1  one-cycle pulse in the first cycle each new K value is presented.
- done  out  1  one-cycle pulse when a single sweep completes normally.

## Operation
- **States:** IDLE, DWELL, DONE.
- **Reset:** state=IDLE, K=0, P=0, busy=0, tone_strobe=0, done=0, and all internal counters are 0.
- **Accept:** a command is accepted when cfg_valid && cfg_ready. On acceptance the block latches all cfg_* fields and sets:
  - K ← cfg_k_start, P ← cfg_phase;
  - tone index ← 0, direction ← up;
  - dwell counter ← max(D,1)−1;
  - tone_strobe ← 1; state → DWELL.
- **DWELL:** the dwell counter decrements each cycle.
  - When the counter is 0 and the tone index < S: K ← K ± step (+ when direction is up, − when down), index++, counter reloads, tone_strobe ← 1.
  - When the counter is 0 and the index == S, the leg ends and the mode decides the next step:
    - single: state → DONE; K holds its last value.
    - repeat: K ← k_start, index ← 0, counter reloads, tone_strobe ← 1.
    - triangle: direction toggles, index ← 1, K ← K ∓ step, tone_strobe ← 1. The turnaround tone is not repeated.
  - Special case: S=0 in repeat or triangle mode holds K = k_start indefinitely, with tone_strobe every D cycles.
- **DONE:** lasts one cycle with done=1, busy=0, cfg_ready=0, then goes to IDLE.
- **Arithmetic:** K updates are modulo 2^KW (they wrap silently, with no saturation). Step-direction subtraction is two's complement at KW bits.
- **Abort:** abort takes priority over everything except rst. In any state, abort makes the next state IDLE; K and P keep their current values, and done and tone_strobe are not asserted. Abort together with cfg_valid in IDLE means the command is not accepted, because cfg_ready is 0.
- **Reset mid-sweep:** the block returns to the reset values on the next edge, regardless of state.
- **Command changes:** cfg_* inputs are ignored outside an accept cycle, so changing them mid-sweep has no effect.

## Timing
- Accept on edge E0 → K, P and tone_strobe are valid after E0 (one-cycle latency).
- Each tone is held exactly max(D,1) cycles. Tone n appears after edge E0 + n·max(D,1).
- Single sweep: busy is high for (S+1)·max(D,1) cycles. done is high in the cycle after the last tone ends. IDLE and cfg_ready=1 follow one cycle later.
- Back-to-back commands: the minimum spacing between accepts is (S+1)·D + 2 cycles.
- The DDS core adds its own input-register and ROM latency downstream; that latency is outside this block.

## Structure
- **Package dds_pkg** holds:
  - the mode enum (MODE_SINGLE, MODE_REPEAT, MODE_TRI);
  - the state enum;
  - default width constants KW, PW, CW, DW.
  
  The DDS core and any later DDS blocks share this package.
- **Sub-module dds_dwell_timer** (DW-bit loadable down-counter):
  - inputs: load, load_val;
  - output: expire, asserted when the count is 0.
- The FSM, tone index and K accumulator stay in the top level.

## Test plan
- **Single up-sweep:** k_start=0x0100_0000, step=0x0010_0000, S=3, D=4, mode=0 → K = 0x0100_0000 / 0x0110_0000 / 0x0120_0000 / 0x0130_0000, 4 cycles each; 4 tone_strobe pulses; busy high for 16 cycles; done in cycle 17 after accept; K holds 0x0130_0000.
- **Negative step with wrap:** k_start=0x0000_0010, step=0xFFFF_FFF0, S=2, D=1 → K = 0x10, 0x00, 0xFFFF_FFF0 on consecutive cycles; done in the next cycle.
- **Triangle:** k_start=100, step=10, S=2, D=2, mode=2 → K = 100, 110, 120, 110, 100, 110, 120…, 2 cycles each; done never asserts. abort then gives IDLE one cycle later with K frozen.
- **Repeat with abort race:** mode=1, S=1, D=3 → K = k_start, k_start+step, k_start… Assert abort together with cfg_valid → no accept, no done, cfg_ready=1 in the cycle after abort falls.
- **Degenerate command:** D=0, S=0, mode=0 → one tone for 1 cycle, then done, then IDLE.
- **Reset mid-sweep:** rst during DWELL → next cycle K=0, P=0, busy=0, cfg_ready=1; a new command is accepted normally.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared types and default widths for the DDS blocks (sweep sequencer, wave core).
package dds_pkg;

    localparam int KW = 32;
    localparam int PW = 11;
    localparam int CW = 16;
    localparam int DW = 16;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_REPEAT = 2'd1,
        MODE_TRI    = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter that measures how long each tone is held.
module dds_dwell_timer #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_val,
    output logic          expire
);

    logic [DW-1:0] count;

    // Parks at zero between tones so expire stays asserted until reloaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Sweep sequencer: steps the DDS frequency word K through a linear tone list,
// holding each tone for a programmed dwell, in single, repeat or triangle mode.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int KW_P = KW,
    parameter int PW_P = PW,
    parameter int CW_P = CW,
    parameter int DW_P = DW
) (
    input  logic            clk,
    input  logic            rst,
    // Handshake: a command transfers on a rising edge where cfg_valid and
    // cfg_ready are both high; cfg_* are ignored on every other edge.
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [KW_P-1:0] cfg_k_start,
    input  logic [KW_P-1:0] cfg_k_step,
    input  logic [CW_P-1:0] cfg_steps,
    input  logic [DW_P-1:0] cfg_dwell,
    input  logic [PW_P-1:0] cfg_phase,
    input  logic [1:0]      cfg_mode,
    input  logic            abort,
    output logic [KW_P-1:0] K,
    output logic [PW_P-1:0] P,
    output logic            busy,
    output logic            tone_strobe,
    output logic            done,
    output state_t          dbg_state
);

    state_t          state;
    logic [KW_P-1:0] k_start_q;
    logic [KW_P-1:0] k_step_q;
    logic [CW_P-1:0] steps_q;
    logic [DW_P-1:0] dwell_m1_q;
    logic [1:0]      mode_q;
    logic [CW_P-1:0] idx;
    logic            dir_down;

    logic            accept;
    logic            expire;
    logic            timer_load;
    logic [DW_P-1:0] cfg_dwell_m1;
    logic [DW_P-1:0] timer_val;

    assign cfg_ready = (state == IDLE) && !abort;
    assign accept    = cfg_valid && cfg_ready;
    assign dbg_state = state;

    // A dwell of 0 behaves like 1, so both reload the counter with 0.
    assign cfg_dwell_m1 = (cfg_dwell == '0) ? '0 : cfg_dwell - 1'b1;

    assign timer_load = accept || ((state == DWELL) && expire && !abort);
    assign timer_val  = accept ? cfg_dwell_m1 : dwell_m1_q;

    dds_dwell_timer #(.DW(DW_P)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .expire   (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            K           <= '0;
            P           <= '0;
            busy        <= 1'b0;
            tone_strobe <= 1'b0;
            done        <= 1'b0;
            k_start_q   <= '0;
            k_step_q    <= '0;
            steps_q     <= '0;
            dwell_m1_q  <= '0;
            mode_q      <= '0;
            idx         <= '0;
            dir_down    <= 1'b0;
        end else begin
            tone_strobe <= 1'b0;
            done        <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            k_start_q   <= cfg_k_start;
                            k_step_q    <= cfg_k_step;
                            steps_q     <= cfg_steps;
                            dwell_m1_q  <= cfg_dwell_m1;
                            mode_q      <= cfg_mode;
                            K           <= cfg_k_start;
                            P           <= cfg_phase;
                            idx         <= '0;
                            dir_down    <= 1'b0;
                            tone_strobe <= 1'b1;
                            busy        <= 1'b1;
                            state       <= DWELL;
                        end
                    end
                    DWELL: begin
                        if (expire) begin
                            if (idx < steps_q) begin
                                K           <= dir_down ? K - k_step_q : K + k_step_q;
                                idx         <= idx + 1'b1;
                                tone_strobe <= 1'b1;
                            end else begin
                                case (mode_q)
                                    MODE_REPEAT: begin
                                        K           <= k_start_q;
                                        idx         <= '0;
                                        tone_strobe <= 1'b1;
                                    end
                                    MODE_TRI: begin
                                        // A one-tone leg has nowhere to turn; keep re-presenting k_start.
                                        if (steps_q == '0) begin
                                            K <= k_start_q;
                                        end else begin
                                            K        <= dir_down ? K + k_step_q : K - k_step_q;
                                            dir_down <= !dir_down;
                                            idx      <= {{(CW_P-1){1'b0}}, 1'b1};
                                        end
                                        tone_strobe <= 1'b1;
                                    end
                                    default: begin
                                        busy  <= 1'b0;
                                        done  <= 1'b1;
                                        state <= DONE;
                                    end
                                endcase
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
